// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between a read-only
// instruction port and a read/write data port, with at most one read in flight.
module mem_port_arbiter #(
  parameter int p_ADDR_BITS     = 32,
  parameter int p_DATA_BITS     = 32,
  parameter int p_STRB_BITS     = p_DATA_BITS / 8,
  parameter int p_RAM_ADDR_BITS = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [p_ADDR_BITS-1:0]     imem_addr,
  input  logic                       imem_valid,
  output logic                       imem_ready,
  output logic                       imem_r_valid,
  input  logic                       imem_r_ready,
  output logic [p_DATA_BITS-1:0]     imem_r_data,
  output logic                       imem_r_resp,
  input  logic [p_ADDR_BITS-1:0]     dmem_addr,
  input  logic                       dmem_cmd,
  input  logic                       dmem_valid,
  output logic                       dmem_ready,
  input  logic                       dmem_w_valid,
  input  logic [p_STRB_BITS-1:0]     dmem_w_strb,
  input  logic [p_DATA_BITS-1:0]     dmem_w_data,
  output logic                       dmem_r_valid,
  input  logic                       dmem_r_ready,
  output logic [p_DATA_BITS-1:0]     dmem_r_data,
  output logic                       dmem_r_resp,
  output logic                       ram_en,
  output logic [p_STRB_BITS-1:0]     ram_we,
  output logic [p_RAM_ADDR_BITS-1:0] ram_addr,
  output logic [p_DATA_BITS-1:0]     ram_wdata,
  input  logic [p_DATA_BITS-1:0]     ram_rdata
);

  localparam int ADDR_HI = p_RAM_ADDR_BITS + 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                 state_q;
  logic                   gnt_dmem_q;   // owner of the outstanding read
  logic                   err_q;
  logic                   r_last_q;     // 1 = dmem was the last port accepted
  logic [p_DATA_BITS-1:0] hold_q;

  logic                   imem_elig;
  logic                   dmem_elig;
  logic                   pick_dmem;
  logic                   pick_imem;
  logic                   idle;
  logic                   imem_acc;
  logic                   dmem_acc;
  logic                   any_acc;
  logic                   is_write;
  logic [p_ADDR_BITS-1:0] sel_addr;
  logic                   in_range;
  logic                   resp_phase;
  logic                   gnt_r_ready;
  logic [p_DATA_BITS-1:0] read_data;

  assign imem_elig = imem_valid;
  assign dmem_elig = dmem_valid && (!dmem_cmd || dmem_w_valid);
  assign pick_dmem = dmem_elig && (!imem_elig || !r_last_q);
  assign pick_imem = imem_elig && !pick_dmem;
  assign idle      = (state_q == S_IDLE) && !rst;
  assign imem_acc  = idle && pick_imem;
  assign dmem_acc  = idle && pick_dmem;
  assign any_acc   = imem_acc || dmem_acc;
  assign is_write  = dmem_acc && dmem_cmd;
  assign sel_addr  = pick_dmem ? dmem_addr : imem_addr;
  assign in_range  = (sel_addr[p_ADDR_BITS-1:ADDR_HI] == '0);

  assign imem_ready = imem_acc;
  assign dmem_ready = dmem_acc;

  // Out-of-range accesses never reach the RAM; writes are dropped silently.
  assign ram_en    = any_acc && in_range;
  assign ram_we    = (is_write && in_range) ? dmem_w_strb : '0;
  assign ram_addr  = ram_en ? sel_addr[ADDR_HI-1:2] : '0;
  assign ram_wdata = (is_write && in_range) ? dmem_w_data : '0;

  assign resp_phase  = (state_q != S_IDLE) && !rst;
  assign gnt_r_ready = gnt_dmem_q ? dmem_r_ready : imem_r_ready;
  assign read_data   = (state_q == S_READ) ? (err_q ? '0 : ram_rdata) : hold_q;

  assign imem_r_valid = resp_phase && !gnt_dmem_q;
  assign imem_r_data  = imem_r_valid ? read_data : '0;
  assign imem_r_resp  = imem_r_valid && err_q;
  assign dmem_r_valid = resp_phase && gnt_dmem_q;
  assign dmem_r_data  = dmem_r_valid ? read_data : '0;
  assign dmem_r_resp  = dmem_r_valid && err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      gnt_dmem_q <= 1'b0;
      err_q      <= 1'b0;
      r_last_q   <= 1'b1;
      hold_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_acc) begin
            r_last_q <= dmem_acc;
          end
          if (any_acc && !is_write) begin
            state_q    <= S_READ;
            gnt_dmem_q <= dmem_acc;
            err_q      <= !in_range;
          end
        end
        S_READ: begin
          if (gnt_r_ready) begin
            state_q <= S_IDLE;
          end else begin
            // RAM output is only valid for one cycle, so park it for the stall.
            hold_q  <= read_data;
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          if (gnt_r_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural single-port RAM model
// attached to the RAM side; each task checks one scenario inline.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic        imem_ready;
  logic        imem_r_valid;
  logic        imem_r_ready;
  logic [31:0] imem_r_data;
  logic        imem_r_resp;
  logic [31:0] dmem_addr;
  logic        dmem_cmd;
  logic        dmem_valid;
  logic        dmem_ready;
  logic        dmem_w_valid;
  logic [3:0]  dmem_w_strb;
  logic [31:0] dmem_w_data;
  logic        dmem_r_valid;
  logic        dmem_r_ready;
  logic [31:0] dmem_r_data;
  logic        dmem_r_resp;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [15:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:65535];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we == 4'b0000) begin
        ram_rdata <= mem[ram_addr];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (ram_we[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
        end
      end
    end
  end

  mem_port_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .imem_addr    (imem_addr),
    .imem_valid   (imem_valid),
    .imem_ready   (imem_ready),
    .imem_r_valid (imem_r_valid),
    .imem_r_ready (imem_r_ready),
    .imem_r_data  (imem_r_data),
    .imem_r_resp  (imem_r_resp),
    .dmem_addr    (dmem_addr),
    .dmem_cmd     (dmem_cmd),
    .dmem_valid   (dmem_valid),
    .dmem_ready   (dmem_ready),
    .dmem_w_valid (dmem_w_valid),
    .dmem_w_strb  (dmem_w_strb),
    .dmem_w_data  (dmem_w_data),
    .dmem_r_valid (dmem_r_valid),
    .dmem_r_ready (dmem_r_ready),
    .dmem_r_data  (dmem_r_data),
    .dmem_r_resp  (dmem_r_resp),
    .ram_en       (ram_en),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    imem_addr    = '0;
    imem_valid   = 1'b0;
    imem_r_ready = 1'b1;
    dmem_addr    = '0;
    dmem_cmd     = 1'b0;
    dmem_valid   = 1'b0;
    dmem_w_valid = 1'b0;
    dmem_w_strb  = '0;
    dmem_w_data  = '0;
    dmem_r_ready = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] flags;
    rst = 1'b1;
    clear_inputs();
    #1;
    flags = {imem_ready, imem_r_valid, imem_r_resp, dmem_ready, dmem_r_valid, dmem_r_resp, ram_en, |ram_we};
    checks++;
    if (flags !== 8'h00) begin
      errors++; $display("FAIL reset_flags: got %b expected %b", flags, 8'h00);
    end
    checks++;
    if ({imem_r_data, dmem_r_data, ram_wdata} !== 96'h0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", {imem_r_data, dmem_r_data, ram_wdata});
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({imem_r_valid, dmem_r_valid, ram_en} !== 3'b000) begin
      errors++; $display("FAIL post_reset_idle: got %b expected 000", {imem_r_valid, dmem_r_valid, ram_en});
    end
    $display("test_reset done");
  endtask

  task automatic test_imem_read();
    mem[4] = 32'hDEADBEEF;
    imem_addr  = 32'h10;
    imem_valid = 1'b1;
    #1;
    checks++;
    if ({imem_ready, dmem_ready, ram_en, ram_we} !== 7'b1010000) begin
      errors++; $display("FAIL imem_accept_ctrl: got %b expected 1010000", {imem_ready, dmem_ready, ram_en, ram_we});
    end
    checks++;
    if (ram_addr !== 16'd4) begin
      errors++; $display("FAIL imem_ram_addr: got %0d expected 4", ram_addr);
    end
    tick();
    imem_valid = 1'b0;
    #1;
    checks++;
    if ({imem_r_valid, imem_r_resp, imem_ready} !== 3'b100) begin
      errors++; $display("FAIL imem_resp_flags: got %b expected 100", {imem_r_valid, imem_r_resp, imem_ready});
    end
    checks++;
    if (imem_r_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL imem_r_data: got %h expected deadbeef", imem_r_data);
    end
    tick();
    checks++;
    if (imem_r_valid !== 1'b0) begin
      errors++; $display("FAIL imem_r_valid_drop: got %b expected 0", imem_r_valid);
    end
    $display("imem read 0x10 -> %h", 32'hDEADBEEF);
  endtask

  task automatic test_round_robin();
    logic exp_i, exp_d;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    mem[8] = 32'h0;
    imem_addr  = 32'h10;
    imem_valid = 1'b1;
    dmem_addr  = 32'h20;
    dmem_cmd   = 1'b0;
    dmem_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      exp_i = (c % 4 == 0);
      exp_d = (c % 4 == 2);
      checks++;
      if ({imem_ready, dmem_ready} !== {exp_i, exp_d}) begin
        errors++; $display("FAIL rr_grant_c%0d: got %b%b expected %b%b", c, imem_ready, dmem_ready, exp_i, exp_d);
      end
      checks++;
      if ({imem_r_valid, dmem_r_valid} !== {c % 4 == 1, c % 4 == 3}) begin
        errors++; $display("FAIL rr_rvalid_c%0d: got %b%b", c, imem_r_valid, dmem_r_valid);
      end
      if (imem_ready) $display("rr cycle %0d grant imem", c);
      if (dmem_ready) $display("rr cycle %0d grant dmem", c);
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_write_strb();
    mem[8] = 32'hAAAAAAAA;
    dmem_addr    = 32'h20;
    dmem_cmd     = 1'b1;
    dmem_valid   = 1'b1;
    dmem_w_valid = 1'b0;
    dmem_w_strb  = 4'b0011;
    dmem_w_data  = 32'h12345678;
    #1;
    checks++;
    if ({dmem_ready, ram_en} !== 2'b00) begin
      errors++; $display("FAIL write_no_wvalid: got %b expected 00", {dmem_ready, ram_en});
    end
    dmem_w_valid = 1'b1;
    #1;
    checks++;
    if ({dmem_ready, ram_en, ram_we} !== 6'b110011) begin
      errors++; $display("FAIL write_ctrl: got %b expected 110011", {dmem_ready, ram_en, ram_we});
    end
    checks++;
    if ({ram_addr, ram_wdata} !== {16'd8, 32'h12345678}) begin
      errors++; $display("FAIL write_addr_data: got %h/%h expected 8/12345678", ram_addr, ram_wdata);
    end
    tick();
    dmem_cmd     = 1'b0;
    dmem_w_valid = 1'b0;
    #1;
    checks++;
    if ({dmem_ready, dmem_r_valid} !== 2'b10) begin
      errors++; $display("FAIL write_then_read_ready: got %b expected 10", {dmem_ready, dmem_r_valid});
    end
    tick();
    dmem_valid = 1'b0;
    #1;
    checks++;
    if ({dmem_r_valid, dmem_r_data} !== {1'b1, 32'hAAAA5678}) begin
      errors++; $display("FAIL strb_readback: got %b/%h expected 1/aaaa5678", dmem_r_valid, dmem_r_data);
    end
    $display("dmem write 0x20 strb 0011 -> readback %h", dmem_r_data);
    tick();
    clear_inputs();
  endtask

  task automatic test_backpressure();
    dmem_addr    = 32'h20;
    dmem_valid   = 1'b1;
    dmem_r_ready = 1'b0;
    #1;
    checks++;
    if (dmem_ready !== 1'b1) begin
      errors++; $display("FAIL bp_accept: got %b expected 1", dmem_ready);
    end
    tick();
    dmem_valid = 1'b0;
    imem_addr  = 32'h10;
    imem_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({dmem_r_valid, dmem_r_data, imem_ready} !== {1'b1, 32'hAAAA5678, 1'b0}) begin
        errors++; $display("FAIL bp_hold_c%0d: got %b/%h/%b expected 1/aaaa5678/0", i, dmem_r_valid, dmem_r_data, imem_ready);
      end
      tick();
    end
    dmem_r_ready = 1'b1;
    #1;
    checks++;
    if ({dmem_r_valid, dmem_r_data, imem_ready} !== {1'b1, 32'hAAAA5678, 1'b0}) begin
      errors++; $display("FAIL bp_handshake: got %b/%h/%b", dmem_r_valid, dmem_r_data, imem_ready);
    end
    tick();
    checks++;
    if ({imem_ready, dmem_r_valid} !== 2'b10) begin
      errors++; $display("FAIL bp_imem_after: got %b expected 10", {imem_ready, dmem_r_valid});
    end
    $display("dmem read stalled 3 cycles -> %h, then imem granted", 32'hAAAA5678);
    tick();
    imem_valid = 1'b0;
    tick();
    clear_inputs();
  endtask

  task automatic test_out_of_range();
    imem_addr  = 32'h0004_0000;
    imem_valid = 1'b1;
    #1;
    checks++;
    if ({imem_ready, ram_en} !== 2'b10) begin
      errors++; $display("FAIL oor_accept: got %b expected 10", {imem_ready, ram_en});
    end
    tick();
    imem_valid = 1'b0;
    #1;
    checks++;
    if ({imem_r_valid, imem_r_resp, imem_r_data} !== {2'b11, 32'h0}) begin
      errors++; $display("FAIL oor_resp: got %b%b/%h expected 11/0", imem_r_valid, imem_r_resp, imem_r_data);
    end
    tick();
    imem_addr  = 32'h13;
    imem_valid = 1'b1;
    tick();
    imem_valid = 1'b0;
    #1;
    checks++;
    if ({imem_r_valid, imem_r_resp, imem_r_data} !== {2'b10, 32'hDEADBEEF}) begin
      errors++; $display("FAIL oor_err_clear: got %b%b/%h expected 10/deadbeef", imem_r_valid, imem_r_resp, imem_r_data);
    end
    $display("imem read 0x40000 -> error response");
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_in_read();
    imem_addr    = 32'h10;
    imem_valid   = 1'b1;
    imem_r_ready = 1'b0;
    tick();
    dmem_addr  = 32'h20;
    dmem_valid = 1'b1;
    #1;
    checks++;
    if (imem_r_valid !== 1'b1) begin
      errors++; $display("FAIL rr_pre_reset_read: got %b expected 1", imem_r_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({imem_r_valid, imem_ready, dmem_ready, ram_en, imem_r_data} !== 36'h0) begin
      errors++; $display("FAIL reset_in_read: got %b%b%b%b/%h expected all 0", imem_r_valid, imem_ready, dmem_ready, ram_en, imem_r_data);
    end
    tick();
    rst = 1'b0;
    imem_r_ready = 1'b1;
    #1;
    checks++;
    if ({imem_ready, dmem_ready, imem_r_valid} !== 3'b100) begin
      errors++; $display("FAIL reset_first_grant: got %b expected 100", {imem_ready, dmem_ready, imem_r_valid});
    end
    $display("reset during READ -> imem granted first");
    tick();
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_imem_read();
    test_round_robin();
    test_write_strb();
    test_backpressure();
    test_out_of_range();
    test_reset_in_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
